// File: rtl/iter_shifter32_if.sv
// Request/response bundle for the iterative shifter.
interface iter_shifter32_if #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 5
);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] Ra;
   logic [AMT_W-1:0]  shift_amt;
   logic              busy;
   logic              done;
   logic              illegal_op;
   logic [DATA_W-1:0] result;

   modport master (
      output start, op, Ra, shift_amt,
      input  busy, done, illegal_op, result
   );

   modport slave (
      input  start, op, Ra, shift_amt,
      output busy, done, illegal_op, result
   );
endinterface

// File: rtl/iter_shifter32.sv
// Iterative one-bit-per-cycle shifter/rotator: SHL, SHR, SHRA, ROL, ROR.
// Latency is shift_amt+1 cycles; illegal ops complete in one cycle.
module iter_shifter32 #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 5
) (
   input  logic              clock,
   input  logic              clear,
   iter_shifter32_if.slave   bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [2:0] OP_SHL  = 3'd0;
   localparam logic [2:0] OP_SHR  = 3'd1;
   localparam logic [2:0] OP_SHRA = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;

   state_t            state_q;
   logic [DATA_W-1:0] work_q, work_d;
   logic [2:0]        op_q;
   logic [AMT_W-1:0]  cnt_q;
   logic              busy_q, done_q, ill_q;
   logic [DATA_W-1:0] result_q;
   logic              op_bad;

   assign op_bad = (bus.op > OP_ROR);

   // One-bit step of the working value for the captured op.
   always_comb begin
      work_d = work_q;
      case (op_q)
         OP_SHL:  work_d = {work_q[DATA_W-2:0], 1'b0};
         OP_SHR:  work_d = {1'b0, work_q[DATA_W-1:1]};
         OP_SHRA: work_d = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
         OP_ROL:  work_d = {work_q[DATA_W-2:0], work_q[DATA_W-1]};
         OP_ROR:  work_d = {work_q[0], work_q[DATA_W-1:1]};
         default: work_d = work_q;
      endcase
   end

   // Control FSM with registered outputs; illegal ops load a zero count so
   // they finish on the first SHIFT edge with the operand untouched.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q  <= IDLE;
         work_q   <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ill_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         ill_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  work_q  <= bus.Ra;
                  op_q    <= bus.op;
                  cnt_q   <= op_bad ? '0 : bus.shift_amt;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_q != '0) begin
                  work_q <= work_d;
                  cnt_q  <= cnt_q - AMT_W'(1);
               end else begin
                  result_q <= work_q;
                  done_q   <= 1'b1;
                  ill_q    <= (op_q > OP_ROR);
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.illegal_op = ill_q;
   assign bus.result     = result_q;

endmodule

// File: tb/tb_iter_shifter32.sv
// Self-checking bench for iter_shifter32: directed cases, random ops with
// input noise while busy, and mid-operation reset.
module tb_iter_shifter32;

   logic clk;
   logic clr;
   int   checks;
   int   errors;

   iter_shifter32_if #(.DATA_W(32), .AMT_W(5)) bus_if ();

   iter_shifter32 #(.DATA_W(32), .AMT_W(5)) dut (
      .clock (clk),
      .clear (clr),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-value shift/rotate by n using plain operators.
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input int n);
      logic [63:0] t;
      case (o)
         3'd0: return a << n;
         3'd1: return a >> n;
         3'd2: return $signed(a) >>> n;
         3'd3: begin t = {a, a} << n; return t[63:32]; end
         3'd4: begin t = {a, a} >> n; return t[31:0]; end
         default: return a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to completion. With noise, start is
   // pulsed while busy (always at cycle 3 and on the done edge) and the
   // operand inputs are scrambled every cycle.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [4:0] n, input bit noise);
      int          lat;
      int          exp_lat;
      logic [31:0] er;
      logic [31:0] held;
      er      = ref_res(o, a, int'(n));
      exp_lat = (o > 3'd4) ? 1 : int'(n) + 1;
      @(negedge clk);
      bus_if.start     = 1'b1;
      bus_if.op        = o;
      bus_if.Ra        = a;
      bus_if.shift_amt = n;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      chk("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
      while (!bus_if.done && lat < 64) begin
         bus_if.Ra        = $urandom;
         bus_if.op        = 3'($urandom);
         bus_if.shift_amt = 5'($urandom);
         bus_if.start     = noise && ((lat + 1 == 3) || (lat + 1 == exp_lat) ||
                                      ($urandom_range(0, 3) == 0));
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      bus_if.start = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("result", bus_if.result, er);
      chk("illegal_op", {31'd0, bus_if.illegal_op}, {31'd0, (o > 3'd4)});
      chk("busy_at_done", {31'd0, bus_if.busy}, 32'd0);
      held = bus_if.result;
      @(posedge clk);
      @(negedge clk);
      chk("done_single", {31'd0, bus_if.done}, 32'd0);
      chk("result_held", bus_if.result, held);
      chk("idle_after", {31'd0, bus_if.busy}, 32'd0);
   endtask

   initial begin
      int  seen_done;
      checks = 0;
      errors = 0;
      clr              = 1'b0;
      bus_if.start     = 1'b0;
      bus_if.op        = '0;
      bus_if.Ra        = '0;
      bus_if.shift_amt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("rst_done", {31'd0, bus_if.done}, 32'd0);
      chk("rst_ill", {31'd0, bus_if.illegal_op}, 32'd0);
      chk("rst_result", bus_if.result, 32'h0);
      clr = 1'b1;

      // Directed cases.
      do_op(3'd3, 32'hF0F0F0F0, 5'd4, 1'b0);
      chk("rol4_abs", bus_if.result, 32'h0F0F0F0F);
      do_op(3'd4, 32'h12345678, 5'd16, 1'b0);
      chk("ror16_abs", bus_if.result, 32'h56781234);
      do_op(3'd0, 32'hAAAAAAAA, 5'd0, 1'b0);
      chk("shl0_abs", bus_if.result, 32'hAAAAAAAA);
      do_op(3'd2, 32'h80000000, 5'd31, 1'b0);
      chk("shra31_abs", bus_if.result, 32'hFFFFFFFF);
      do_op(3'd1, 32'h80000000, 5'd31, 1'b0);
      chk("shr31_abs", bus_if.result, 32'h00000001);
      do_op(3'd3, 32'hAAAAAAAA, 5'd31, 1'b0);
      chk("rol31_abs", bus_if.result, 32'h55555555);
      do_op(3'd6, 32'hDEADBEEF, 5'd20, 1'b1);
      chk("illegal_abs", bus_if.result, 32'hDEADBEEF);
      do_op(3'd3, 32'h000000F1, 5'd8, 1'b1);
      chk("rol8_abs", bus_if.result, 32'h0000F100);

      // Random operations, half with start/operand noise while busy.
      for (int i = 0; i < 24; i++) begin
         do_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
      end

      // Reset at cycle 5 of a 20-step shift aborts without done.
      @(negedge clk);
      bus_if.start     = 1'b1;
      bus_if.op        = 3'd0;
      bus_if.Ra        = 32'h0000FFFF;
      bus_if.shift_amt = 5'd20;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("busy_before_clr", {31'd0, bus_if.busy}, 32'd1);
      clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("clr_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("clr_result", bus_if.result, 32'h0);
      chk("clr_done", {31'd0, bus_if.done}, 32'd0);
      // clear wins over start on the same edge.
      bus_if.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("clr_prio_busy", {31'd0, bus_if.busy}, 32'd0);
      bus_if.start = 1'b0;
      clr = 1'b1;
      seen_done = 0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_if.done) seen_done++;
      end
      chk("no_done_after_abort", 32'(seen_done), 32'd0);
      do_op(3'd3, 32'h00000001, 5'd1, 1'b0);
      chk("post_clr_rol1", bus_if.result, 32'h00000002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
